jtcop_objdma: RTL and testbench

Object-RAM copy engine for the Dec0-family main board. On each object-copy trigger (*DM, produced by the address decoder at VBLANK start), it copies the 1024-word CPU-visible object table into the object chip's private frame buffer. The object renderer then scans a stable sprite list for the whole next frame. It sits between the decoder/object-RAM (upstream) and the object line renderer (downstream).

---
 rtl/jtcop_objdma_if.sv | 12 +
 rtl/jtcop_objdma.sv | 106 ++++++++++
 tb/tb_jtcop_objdma.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_objdma_if.sv
// Object-copy memory bus: read side into CPU object RAM, write side into the
// object chip frame buffer.
interface jtcop_objdma_if #(parameter int AW = 10);
    logic [AW-1:0] src_addr;
    logic [15:0]   src_data;
    logic [AW-1:0] dst_addr;
    logic [15:0]   dst_data;
    logic          dst_we;

    modport master (output src_addr, dst_addr, dst_data, dst_we, input src_data);
    modport slave  (input src_addr, dst_addr, dst_data, dst_we, output src_data);
endinterface

// File: rtl/jtcop_objdma.sv
// Object-RAM to frame-buffer copy engine, triggered at VBLANK start.
// Define JTCOP_OBJDMA_HALT_EN to request/await the 68000 bus before copying.
module jtcop_objdma #(
    parameter int AW = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen,
    input  logic                  obj_copy,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_brn,
    input  logic                  cpu_bgn,
    jtcop_objdma_if.master        bus
);

    typedef enum logic [1:0] {IDLE, REQ, COPY, LAST} state_t;

    localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] dst_addr_q, dst_addr_d;
    logic          obj_l_q, obj_l_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          rise, trig, wr_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dst_addr_q <= '0;
            obj_l_q    <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dst_addr_q <= dst_addr_d;
            obj_l_q    <= obj_l_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dst_addr_d = dst_addr_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        obj_l_d    = obj_copy;
        rise       = obj_copy & ~obj_l_q;
        trig       = (rise | pend_q) && (state_q == IDLE);
        // Edges seen between cen cycles are held until the next cen; edges while busy are lost.
        if (cen)
            pend_d = 1'b0;
        else if (rise && state_q == IDLE)
            pend_d = 1'b1;
        if (cen) begin
            case (state_q)
                IDLE: if (trig) begin
                    cnt_d = '0;
`ifdef JTCOP_OBJDMA_HALT_EN
                    state_d = REQ;
`else
                    state_d = COPY;
`endif
                end
`ifdef JTCOP_OBJDMA_HALT_EN
                REQ: if (!cpu_bgn) state_d = COPY;
`endif
                COPY: begin
                    dst_addr_d = cnt_q[AW-1:0];
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = LAST;
                end
                LAST: begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Word k-1 is written while word k is being addressed; LAST drains the final word.
    assign wr_phase     = (state_q == COPY && cnt_q != '0) || state_q == LAST;
    assign bus.src_addr = cnt_q[AW-1:0];
    assign bus.dst_addr = dst_addr_q;
    assign bus.dst_data = wr_phase ? bus.src_data : 16'h0000;
    assign bus.dst_we   = cen & wr_phase;
    assign busy         = state_q != IDLE;
    assign done         = done_q;

`ifdef JTCOP_OBJDMA_HALT_EN
    assign cpu_brn = ~busy;
`else
    logic unused_bgn;
    assign unused_bgn = cpu_bgn;
    assign cpu_brn    = 1'b1;
`endif

endmodule

// File: tb/tb_jtcop_objdma.sv
// Scoreboard bench for jtcop_objdma: stimulus queues expected writes, a
// negedge monitor pops and compares every dst_we strobe.
module tb_jtcop_objdma;
    localparam int AW = 10;
    localparam int N  = 1 << AW;
`ifdef JTCOP_OBJDMA_HALT_EN
    localparam int REQ_LAT = 1;
`else
    localparam int REQ_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b1;
    logic obj_copy = 1'b0;
    logic cpu_bgn;
    logic busy, done, cpu_brn;
    logic cen3 = 1'b0;
    int   cyc = 0;

    jtcop_objdma_if #(.AW(AW)) bus();

    jtcop_objdma #(.AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .obj_copy(obj_copy),
        .busy    (busy),
        .done    (done),
        .cpu_brn (cpu_brn),
        .cpu_bgn (cpu_bgn),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] src_mem [N];
    initial for (int k = 0; k < N; k++) src_mem[k] = 16'(k) ^ 16'hA5A5;
    always @(posedge clk) if (cen) bus.src_data <= src_mem[bus.src_addr];

    initial forever begin
        @(negedge clk);
        cen = cen3 ? (cyc % 3 == 0) : 1'b1;
    end

    typedef struct packed { logic [AW-1:0] a; logic [15:0] d; } wr_t;
    wr_t exp_q[$];

    int pass_cnt = 0, tot_cnt = 0;
    int wr_cnt, busy_cnt, done_cnt, first_wr, last_wr, done_cyc, last_addr, trig_cyc;
    logic done_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    endtask

    initial forever begin
        wr_t e;
        @(negedge clk);
        if (bus.dst_we) begin
            if (exp_q.size() == 0) chk("spurious_write_queue", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.dst_addr, e.a);
                chk("wr_data", bus.dst_data, e.d);
                chk("wr_on_cen", cen, 1);
            end
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr   = cyc;
            last_addr = bus.dst_addr;
        end
        if (busy) busy_cnt++;
        if (done) begin
            chk("done_width", done_prev, 0);
            chk("brn_on_done", cpu_brn, 1);
            done_cnt++;
            done_cyc = cyc;
        end
        done_prev = done;
    end

    task automatic clr();
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; first_wr = -1;
        last_wr = -1; done_cyc = -1; last_addr = -1;
    endtask

    // Trigger is high during period trig_cyc; all latencies are counted from it.
    task automatic trigger(input int len);
        wr_t e;
        @(negedge clk);
        clr();
        for (int k = 0; k < N; k++) begin
            e.a = AW'(k);
            e.d = 16'(k) ^ 16'hA5A5;
            exp_q.push_back(e);
        end
        obj_copy = 1'b1;
        trig_cyc = cyc;
        repeat (len) @(negedge clk);
        obj_copy = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < budget) begin @(posedge clk); i++; end
        chk("done_timeout", done_cnt, d0 + 1);
    endtask

    task automatic wait_addr(input int a, input int budget);
        int i = 0;
        while (!(wr_cnt > 0 && last_addr >= a) && i < budget) begin @(posedge clk); i++; end
        chk("addr_timeout", 32'(last_addr >= a), 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_src_addr", bus.src_addr, 0);
        chk("rst_dst_addr", bus.dst_addr, 0);
        chk("rst_dst_data", bus.dst_data, 0);
        chk("rst_dst_we",   bus.dst_we, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_done",     done, 0);
        chk("rst_cpu_brn",  cpu_brn, 1);
    endtask

    initial begin
        int w0, d;
`ifdef JTCOP_OBJDMA_HALT_EN
        cpu_bgn = 1'b0;
`else
        cpu_bgn = 1'b1;
`endif
        clr();
        repeat (3) @(negedge clk);
        #1 chk_reset_vals();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic copy, cen always high
        trigger(1);
        wait_done(1200);
        repeat (3) @(negedge clk);
        chk("basic_writes",   wr_cnt, N);
        chk("basic_busy_len", busy_cnt, N + 1 + REQ_LAT);
        chk("basic_first_we", first_wr - trig_cyc, 2 + REQ_LAT);
        chk("basic_last_we",  last_wr - trig_cyc, N + 1 + REQ_LAT);
        chk("basic_done_lat", done_cyc - trig_cyc, N + 2 + REQ_LAT);
        chk("basic_queue",    exp_q.size(), 0);

        // Retrigger while busy is dropped
        trigger(1);
        wait_addr(300, 1200);
        @(negedge clk) obj_copy = 1'b1;
        @(negedge clk) obj_copy = 1'b0;
        wait_done(1200);
        repeat (20) @(negedge clk);
        chk("retrig_dones",  done_cnt, 1);
        chk("retrig_writes", wr_cnt, N);
        chk("retrig_queue",  exp_q.size(), 0);

        // cen every third clk; the trigger lands on a non-cen clk
        cen3 = 1'b1;
        do @(negedge clk); while (cyc % 3 != 1);
        trigger(1);
        wait_done(3600);
        d = done_cyc - trig_cyc;
        chk("cen3_done_lat", 32'(d >= 3073 + 3*REQ_LAT && d <= 3077 + 3*REQ_LAT), 1);
        chk("cen3_writes",   wr_cnt, N);
        chk("cen3_queue",    exp_q.size(), 0);
        @(negedge clk) cen3 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-copy, then a fresh copy from word 0
        trigger(1);
        wait_addr(500, 1200);
        @(negedge clk) rst_n = 1'b0;
        #1 chk_reset_vals();
        exp_q.delete();
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        chk("rst_no_writes", wr_cnt, w0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        trigger(1);
        wait_done(1200);
        repeat (3) @(negedge clk);
        chk("rerun_writes", wr_cnt, N);
        chk("rerun_queue",  exp_q.size(), 0);

        // Wide trigger gives one copy; only a new rising edge restarts
        trigger(5000);
        repeat (50) @(negedge clk);
        chk("wide_dones",  done_cnt, 1);
        chk("wide_writes", wr_cnt, N);
        chk("wide_busy",   busy, 0);
        trigger(1);
        wait_done(1200);
        repeat (3) @(negedge clk);
        chk("wide_rerun_writes", wr_cnt, N);

`ifdef JTCOP_OBJDMA_HALT_EN
        // Halt: wait for grant with bus requested and no writes
        begin
            int brn_bad = 0, q;
            cpu_bgn = 1'b1;
            trigger(1);
            repeat (20) begin
                @(negedge clk);
                if (cpu_brn !== 1'b0 || bus.dst_we !== 1'b0) brn_bad++;
            end
            chk("halt_wait_ok", brn_bad, 0);
            chk("halt_no_writes", wr_cnt, 0);
            cpu_bgn = 1'b0;
            q = cyc;
            wait_done(1200);
            repeat (3) @(negedge clk);
            chk("halt_first_we", first_wr - q, 2);
            chk("halt_writes",   wr_cnt, N);
        end
`else
        chk("brn_tied_high", cpu_brn, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end
endmodule
